// File: rtl/cdb_arbiter_if.sv
// Result-packet type plus the bundle between the execute-stage units and the CDB arbiter.
// Handshake: a unit raises fu_valid[i] with a stable fu_pkt[i]; the packet is taken in the cycle fu_yumi[i]=1.
package cdb_pkg;
  typedef struct packed {
    logic [3:0]  dest_rob_entry;
    logic [31:0] result;
    logic        branch_result;
    logic        from_memory;
  } cdb_packet_t;
endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU = 4
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]                fu_valid;
  cdb_pkg::cdb_packet_t [NUM_FU-1:0] fu_pkt;
  logic [NUM_FU-1:0]                fu_yumi;
  logic                             flush;
  logic                             cdb_valid;
  cdb_pkg::cdb_packet_t             cdb_out;
  logic [31:0]                      bcast_count;
  logic [PTR_W-1:0]                 rr_ptr;   // debug view of the round-robin pointer

  modport master (
    output fu_valid, fu_pkt, flush,
    input  fu_yumi, cdb_valid, cdb_out, bcast_count, rr_ptr
  );

  modport slave (
    input  fu_valid, fu_pkt, flush,
    output fu_yumi, cdb_valid, cdb_out, bcast_count, rr_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one functional unit per cycle (same-cycle yumi)
// and broadcasts the chosen packet on the common data bus one cycle later.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              grant;
  logic [NUM_FU-1:0] yumi;
  cdb_packet_t       out_q;
  logic              valid_q;
  logic [31:0]       count_q;

  // Search starts at rr_ptr and wraps; reset and flush both suppress any grant.
  always_comb begin
    yumi      = '0;
    grant     = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    if (!reset && !bus.flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        cand_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_FU);
        if (!grant && bus.fu_valid[cand_idx]) begin
          grant     = 1'b1;
          grant_idx = cand_idx;
        end
      end
      if (grant) yumi[grant_idx] = 1'b1;
    end
  end

  assign next_ptr = (int'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      out_q    <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else if (grant) begin
      valid_q  <= 1'b1;
      out_q    <= bus.fu_pkt[grant_idx];
      rr_ptr_q <= next_ptr;
      count_q  <= count_q + 32'd1;
    end else begin
      // Pointer holds on idle and flush cycles so fairness order is preserved.
      valid_q  <= 1'b0;
      out_q    <= '0;
    end
  end

  assign bus.fu_yumi     = yumi;
  assign bus.cdb_valid   = valid_q;
  assign bus.cdb_out     = out_q;
  assign bus.bcast_count = count_q;
  assign bus.rr_ptr      = rr_ptr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin order, flush and mid-stream reset.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_fail;

  cdb_packet_t p [4];

  cdb_arbiter_if #(.NUM_FU(4)) bus ();

  cdb_arbiter #(.NUM_FU(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cdb_packet_t mk(input logic [3:0] rob, input logic [31:0] res,
                                     input logic br, input logic mem);
    cdb_packet_t t;
    t.dest_rob_entry = rob;
    t.result         = res;
    t.branch_result  = br;
    t.from_memory    = mem;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pkts();
    for (int u = 0; u < 4; u++) bus.fu_pkt[u] = p[u];
  endtask

  int          off [4];
  int          order [8];
  logic [3:0]  v;

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    p[0] = mk(4'd1,  32'h1111_0000, 1'b1, 1'b0);
    p[1] = mk(4'd2,  32'hdead_beef, 1'b0, 1'b1);
    p[2] = mk(4'd5,  32'd10,        1'b0, 1'b0);
    p[3] = mk(4'd15, 32'hffff_fffe, 1'b1, 1'b1);
    order = '{2, 3, 0, 1, 2, 3, 0, 1};
    reset = 1'b1;
    bus.fu_valid = '0;
    bus.flush    = 1'b0;
    drive_pkts();

    // reset with no requests
    tick();
    chk("reset_yumi", 64'(bus.fu_yumi), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_yumi",  64'(bus.fu_yumi), 64'd0);
      chk("idle_valid", 64'(bus.cdb_valid), 64'd0);
      chk("idle_out",   64'(bus.cdb_out), 64'd0);
      chk("idle_count", 64'(bus.bcast_count), 64'd0);
    end

    // single requester: unit 2
    bus.fu_valid = 4'b0100;
    #1;
    chk("single_yumi", 64'(bus.fu_yumi), 64'b0100);
    tick();
    bus.fu_valid = '0;
    chk("single_valid", 64'(bus.cdb_valid), 64'd1);
    chk("single_out",   64'(bus.cdb_out), 64'(p[2]));
    chk("single_count", 64'(bus.bcast_count), 64'd1);
    chk("single_ptr",   64'(bus.rr_ptr), 64'd3);
    tick();
    chk("single_idle_valid", 64'(bus.cdb_valid), 64'd0);
    chk("single_idle_out",   64'(bus.cdb_out), 64'd0);
    chk("single_idle_count", 64'(bus.bcast_count), 64'd1);

    // pointer at 3, units 1 and 3 request: 3 first, then wrap to 1
    bus.fu_valid = 4'b1010;
    #1;
    chk("wrap_yumi3", 64'(bus.fu_yumi), 64'b1000);
    tick();
    bus.fu_valid = 4'b0010;
    chk("wrap_out3", 64'(bus.cdb_out), 64'(p[3]));
    #1;
    chk("wrap_yumi1", 64'(bus.fu_yumi), 64'b0010);
    tick();
    bus.fu_valid = '0;
    chk("wrap_out1",   64'(bus.cdb_out), 64'(p[1]));
    chk("wrap_valid1", 64'(bus.cdb_valid), 64'd1);
    chk("wrap_count",  64'(bus.bcast_count), 64'd3);
    chk("wrap_ptr",    64'(bus.rr_ptr), 64'd2);
    tick();

    // all units busy; each drops valid for two cycles after its grant
    for (int u = 0; u < 4; u++) off[u] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int u = 0; u < 4; u++) begin
        v[u] = (off[u] == 0);
        if (off[u] > 0) off[u]--;
      end
      bus.fu_valid = v;
      #1;
      chk("rr_yumi", 64'(bus.fu_yumi), 64'(1) << order[c]);
      off[order[c]] = 2;
      tick();
      chk("rr_valid", 64'(bus.cdb_valid), 64'd1);
      chk("rr_out",   64'(bus.cdb_out), 64'(p[order[c]]));
    end
    bus.fu_valid = '0;
    chk("rr_count", 64'(bus.bcast_count), 64'd11);
    chk("rr_ptr",   64'(bus.rr_ptr), 64'd2);
    tick();

    // flush suppresses the grant and leaves the pointer alone
    bus.fu_valid = 4'b0001;
    bus.flush    = 1'b1;
    #1;
    chk("flush_yumi", 64'(bus.fu_yumi), 64'd0);
    tick();
    bus.flush = 1'b0;
    chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
    chk("flush_ptr",   64'(bus.rr_ptr), 64'd2);
    #1;
    chk("post_flush_yumi", 64'(bus.fu_yumi), 64'b0001);
    tick();
    bus.fu_valid = 4'b0010;
    chk("post_flush_out",   64'(bus.cdb_out), 64'(p[0]));
    chk("post_flush_count", 64'(bus.bcast_count), 64'd12);
    // packet already registered stays visible in the flush cycle
    bus.flush = 1'b1;
    #1;
    chk("flush2_yumi",  64'(bus.fu_yumi), 64'd0);
    chk("flush2_valid", 64'(bus.cdb_valid), 64'd1);
    tick();
    bus.flush = 1'b0;
    chk("flush2_next_valid", 64'(bus.cdb_valid), 64'd0);
    chk("flush2_ptr",        64'(bus.rr_ptr), 64'd1);

    // grant to unit 1, then reset in the following cycle
    #1;
    chk("pre_reset_yumi", 64'(bus.fu_yumi), 64'b0010);
    tick();
    bus.fu_valid = 4'b1000;
    reset = 1'b1;
    #1;
    chk("reset_mid_yumi",  64'(bus.fu_yumi), 64'd0);
    chk("reset_mid_valid", 64'(bus.cdb_valid), 64'd1);
    tick();
    reset = 1'b0;
    chk("after_reset_valid", 64'(bus.cdb_valid), 64'd0);
    chk("after_reset_count", 64'(bus.bcast_count), 64'd0);
    chk("after_reset_out",   64'(bus.cdb_out), 64'd0);
    chk("after_reset_ptr",   64'(bus.rr_ptr), 64'd0);
    #1;
    chk("after_reset_yumi", 64'(bus.fu_yumi), 64'b1000);
    tick();
    bus.fu_valid = '0;
    chk("after_reset_out3",  64'(bus.cdb_out), 64'(p[3]));
    chk("after_reset_cnt1",  64'(bus.bcast_count), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the functional-unit result handshake (valid_out/yumi_in). Collects finished results from all execute-stage units: ALU, multiply, divide, load/store.
- Picks one unit per cycle by round-robin and returns yumi to that unit in the same cycle.
- Registers the chosen CDB_packet_t and broadcasts it on the common data bus to the ROB and reservation stations one cycle later.

Parameters:
- NUM_FU, 4, number of functional units requesting the CDB (index 0..NUM_FU-1).
- PTR_W, $clog2(NUM_FU), width of the round-robin pointer (derived, not overridden).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- fu_valid  input  NUM_FU  per-unit result-valid (unit's valid_out).
- fu_pkt  input  NUM_FU x CDB_packet_t  per-unit result packet (dest_ROB_entry[3:0], result[31:0], branch_result, from_memory).
- fu_yumi  output  NUM_FU  one-hot grant; drives each unit's yumi_in.
- flush  input  1  pipeline flush (mispredict); suppresses grants.
- cdb_valid  output  1  broadcast valid.
- cdb_out  output  CDB_packet_t  broadcast packet.
- bcast_count  output  32  number of packets broadcast since reset.

Behaviour:
- Reset (one clk edge with reset=1):
  - cdb_valid=0, cdb_out=all zeros, rr_ptr=0, bcast_count=0.
  - fu_yumi=0 combinationally while reset=1.
- Producer rule: a unit holds fu_valid[i] and fu_pkt[i] stable until the cycle it sees fu_yumi[i]=1. It drops fu_valid[i] no later than the cycle after the yumi.
- Grant (combinational):
  - If reset=0 and flush=0, search fu_valid starting at index rr_ptr, ascending and wrapping modulo NUM_FU. The first set bit i gets fu_yumi[i]=1.
  - At most one fu_yumi bit is high. fu_yumi=0 if no unit is valid or flush=1.
- On the edge of a grant to unit i:
  - cdb_out<=fu_pkt[i], cdb_valid<=1.
  - rr_ptr<=(i+1) mod NUM_FU.
  - bcast_count<=bcast_count+1, wrapping at 2^32.
- On an edge with no grant: cdb_valid<=0, cdb_out<=0; rr_ptr and bcast_count hold.
- Latency: yumi in cycle N gives the broadcast in cycle N+1. Throughput is one packet per cycle, no bubbles, while any unit is valid.
- No backpressure on the CDB. A broadcast is always consumed in its valid cycle.
- Fairness: a unit whose fu_valid is held continuously is granted within NUM_FU cycles.
- flush:
  - No grant in the flush cycle; cdb_valid=0 the following cycle.
  - rr_ptr is unchanged.
  - A packet already registered (cdb_valid=1 in the flush cycle) is still presented that cycle; the ROB discards it.
- Reset mid-stream: the registered packet is dropped (cdb_valid=0 next cycle). No yumi is issued during reset, so no unit loses a result it has not handed off.
- Packet fields are copied unchanged; branch_result and from_memory pass through.

Test Plan:
- Reset, all fu_valid=0 for 5 cycles -> fu_yumi=0, cdb_valid=0, cdb_out=0, bcast_count=0 throughout.
- Only fu_valid[2]=1 with pkt {rob=5, result=10, 0, 0} -> fu_yumi=4'b0100 that cycle; next cycle cdb_valid=1, cdb_out={5,10,0,0}, bcast_count=1; rr_ptr=3.
- fu_valid=4'b1111 held, each unit drops valid the cycle after its yumi and reasserts 2 cycles later -> grant order 0,1,2,3,0,...; cdb_valid=1 every cycle; no unit waits more than 4 cycles.
- rr_ptr=3 (after a grant to unit 2), fu_valid=4'b1010 -> unit 3 granted first, then unit 1; cdb_out matches each unit's packet in order.
- fu_valid=4'b0001 with flush=1 for one cycle -> fu_yumi=0 that cycle and cdb_valid=0 next cycle. With flush=0 the following cycle, unit 0 is granted and broadcast one cycle later.
- Grant to unit 1 in cycle N, reset=1 in cycle N+1 -> cdb_valid=0 and bcast_count=0 in N+2; fu_yumi=0 during reset.
